fp_mul_booth_seq: RTL

- Iterative radix-4 Booth mantissa multiplier: first stage of the FP multiply datapath, directly upstream of the normalization stage.
- Accepts two packed IEEE-754 operands over a valid/ready handshake and unpacks them (hidden bit, flush of exp==0).
- Produces the exact 2*(MAN_W+1)-bit significand product, plus product sign, biased exponent sum and special-operand flags, for the normalizer to consume.

---
 rtl/fp_mul_booth_seq_pkg.sv | 30 +++
 rtl/fp_mul_booth_seq_if.sv | 28 ++
 rtl/fp_mul_booth_enc.sv | 28 ++
 rtl/fp_mul_booth_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fp_mul_booth_seq_pkg.sv
// Shared sizing, FSM state type and radix-4 Booth digit decode for the
// sequential FP significand multiplier.
package fp_mul_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int N_DIG = (MAN_W + 3) / 2;
    localparam int FP_W  = EXP_W + MAN_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef logic signed [2:0] booth_digit_t;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}
    function automatic booth_digit_t booth_decode(input logic [2:0] trip);
        case (trip)
            3'b001, 3'b010: return 3'sd1;
            3'b011:         return 3'sd2;
            3'b100:         return -3'sd2;
            3'b101, 3'b110: return -3'sd1;
            default:        return 3'sd0;
        endcase
    endfunction

endpackage

// File: rtl/fp_mul_booth_seq_if.sv
// Operand/result handshake bundle between the unpacker upstream, the Booth
// multiplier and the normalizer downstream.
interface fp_mul_booth_seq_if;
    import fp_mul_pkg::*;

    logic                          in_valid;
    logic                          in_ready;
    logic [FP_W-1:0]               fp_X;
    logic [FP_W-1:0]               fp_Y;
    logic                          out_valid;
    logic                          out_ready;
    logic [2*(MAN_W+1)-1:0]        frc_Z_full;
    logic                          sign_Z;
    logic signed [EXP_W+1:0]       exp_Z_pre;
    logic                          zero_Z;
    logic                          nif_Z;

    modport master (
        output in_valid, fp_X, fp_Y, out_ready,
        input  in_ready, out_valid, frc_Z_full, sign_Z, exp_Z_pre, zero_Z, nif_Z
    );

    modport slave (
        input  in_valid, fp_X, fp_Y, out_ready,
        output in_ready, out_valid, frc_Z_full, sign_Z, exp_Z_pre, zero_Z, nif_Z
    );

endinterface

// File: rtl/fp_mul_booth_enc.sv
// Radix-4 Booth partial product generator: maps a multiplier triplet and the
// multiplicand A to the signed product digit*A in -2A..+2A.
module fp_mul_booth_enc
    import fp_mul_pkg::*;
(
    input  logic [2:0]              triplet_i,
    input  logic [MAN_W:0]          a_i,
    output logic signed [MAN_W+2:0] pp_o
);

    logic signed [MAN_W+2:0] a_ext;

    assign a_ext = {2'b00, a_i};

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and a latch cannot be inferred.
    always_comb begin
        pp_o = '0;
        case (booth_decode(triplet_i))
            3'sd1:   pp_o = a_ext;
            3'sd2:   pp_o = a_ext <<< 1;
            -3'sd1:  pp_o = -a_ext;
            -3'sd2:  pp_o = -(a_ext <<< 1);
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/fp_mul_booth_seq.sv
// Iterative radix-4 Booth significand multiplier, one digit per cycle.
// Define MUL_BOOTH_EARLY_OUT_EN to skip iteration when an operand is flushed.
module fp_mul_booth_seq
    import fp_mul_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    fp_mul_booth_seq_if.slave bus
);

    localparam int SIG_W  = MAN_W + 1;
    localparam int HW     = SIG_W + 3;
    localparam int LW     = 2 * N_DIG;
    localparam int ACC_W  = HW + LW;
    localparam int BQ_W   = LW + 1;
    localparam int CNT_W  = $clog2(N_DIG + 1);
    localparam int PROD_W = 2 * SIG_W;

`ifdef MUL_BOOTH_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SIG_W-1:0]        a_q, a_d;
    logic [BQ_W-1:0]         b_q, b_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    sign_q, sign_d;
    logic signed [EXP_W+1:0] exp_q, exp_d;
    logic                    zero_q, zero_d;
    logic                    nif_q, nif_d;

    logic                    in_ready, out_valid;
    logic [EXP_W-1:0]        exp_x, exp_y;
    logic                    x_flush, y_flush;
    logic [SIG_W-1:0]        sig_x, sig_y;
    logic signed [MAN_W+2:0] pp;
    logic signed [HW-1:0]    hi_sum;
    logic signed [ACC_W-1:0] acc_step;

    assign exp_x   = bus.fp_X[FP_W-2 -: EXP_W];
    assign exp_y   = bus.fp_Y[FP_W-2 -: EXP_W];
    assign x_flush = (exp_x == '0);
    assign y_flush = (exp_y == '0);
    assign sig_x   = x_flush ? '0 : {1'b1, bus.fp_X[MAN_W-1:0]};
    assign sig_y   = y_flush ? '0 : {1'b1, bus.fp_Y[MAN_W-1:0]};

    fp_mul_booth_enc u_enc (
        .triplet_i (b_q[2:0]),
        .a_i       (a_q),
        .pp_o      (pp)
    );

    // Digit enters at weight 4^N_DIG; each shift of 2 brings digit i to 4^i.
    assign hi_sum   = $signed(acc_q[ACC_W-1 -: HW]) + HW'(pp);
    assign acc_step = {hi_sum, acc_q[LW-1:0]};

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid)
                    state_d = (EARLY_OUT && (x_flush || y_flush)) ? DONE : CALC;
            end
            CALC: begin
                if (cnt_q == CNT_W'(N_DIG - 1))
                    state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        sign_d = sign_q;
        exp_d  = exp_q;
        zero_d = zero_q;
        nif_d  = nif_q;
        if (state_q == IDLE && bus.in_valid) begin
            a_d    = sig_x;
            b_d    = {{(BQ_W - SIG_W - 1){1'b0}}, sig_y, 1'b0};
            acc_d  = '0;
            cnt_d  = '0;
            sign_d = bus.fp_X[FP_W-1] ^ bus.fp_Y[FP_W-1];
            exp_d  = {2'b00, exp_x} + {2'b00, exp_y} - (EXP_W + 2)'(BIAS);
            zero_d = x_flush || y_flush;
            nif_d  = (&exp_x) || (&exp_y);
        end else if (state_q == CALC) begin
            acc_d = acc_step >>> 2;
            b_d   = b_q >> 2;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            zero_q  <= 1'b0;
            nif_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            zero_q  <= zero_d;
            nif_q   <= nif_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.frc_Z_full = acc_q[PROD_W-1:0];
    assign bus.sign_Z     = sign_q;
    assign bus.exp_Z_pre  = exp_q;
    assign bus.zero_Z     = zero_q;
    assign bus.nif_Z      = nif_q;

endmodule
